ppt_placar: RTL and testbench

Match scorekeeper for the rock-paper-scissors datapath. It sits downstream of the combinational round judge and consumes each judged round result (S1,S2). It accumulates per-player scores over a best-of-N match and declares the match winner, using the judge's own 2-bit result encoding. It is the result-consuming end of the judge interface: the judge produces one result per round, and this block sequences the rounds into a match.

---
 rtl/ppt_pkg.sv | 21 ++
 rtl/ppt_res_decode.sv | 26 ++
 rtl/ppt_placar.sv | 141 ++++++++++++++
 tb/tb_ppt_placar.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ppt_pkg.sv
// rtl/ppt_pkg.sv - shared result codes, FSM states and move codes for the rock-paper-scissors datapath
package ppt_pkg;

  localparam logic [1:0] RES_TIE = 2'b11;
  localparam logic [1:0] RES_A   = 2'b10;
  localparam logic [1:0] RES_B   = 2'b01;
  localparam logic [1:0] RES_INV = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Move codes as presented to the round judge upstream of the scorekeeper
  localparam logic [3:0] MOVE_TESOURA  = 4'b0000;
  localparam logic [3:0] MOVE_PEDRA    = 4'b0001;
  localparam logic [3:0] MOVE_PAPEL    = 4'b1010;
  localparam logic [3:0] MOVE_INVALIDO = 4'b1011;

endpackage

// File: rtl/ppt_res_decode.sv
// rtl/ppt_res_decode.sv - one-hot decode of the judge result {S1,S2}
module ppt_res_decode
  import ppt_pkg::*;
(
  input  logic S1,
  input  logic S2,
  output logic win_a,
  output logic win_b,
  output logic tie,
  output logic inv
);

  always_comb begin
    win_a = 1'b0;
    win_b = 1'b0;
    tie   = 1'b0;
    inv   = 1'b0;
    case ({S1, S2})
      RES_A:   win_a = 1'b1;
      RES_B:   win_b = 1'b1;
      RES_TIE: tie   = 1'b1;
      default: inv   = 1'b1;
    endcase
  end

endmodule

// File: rtl/ppt_placar.sv
// rtl/ppt_placar.sv - best-of-N match scorekeeper fed by the round judge
// Optional feature: PPT_INVALID_ABORT_EN aborts a match after three consecutive invalid results.
module ppt_placar
  import ppt_pkg::*;
#(
  parameter int WINS_TO_MATCH = 2,
  parameter int MAX_ROUNDS    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       res_valid,
  input  logic       S1,
  input  logic       S2,
  output logic       ready,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [3:0] rounds,
  output logic       done,
  output logic [1:0] winner
);

  localparam logic [3:0] WINS_4 = 4'(WINS_TO_MATCH);
  localparam logic [3:0] MAX_4  = 4'(MAX_ROUNDS);

  state_t     state_q, state_d;
  logic [3:0] score_a_q, score_a_d;
  logic [3:0] score_b_q, score_b_d;
  logic [3:0] rounds_q, rounds_d;
  logic [1:0] winner_q, winner_d;

  logic win_a, win_b, tie, inv;
  logic res_ok, accept;
  logic [3:0] a_nxt, b_nxt, r_nxt;

  ppt_res_decode u_decode (
    .S1    (S1),
    .S2    (S2),
    .win_a (win_a),
    .win_b (win_b),
    .tie   (tie),
    .inv   (inv)
  );

  assign res_ok = (win_a | win_b | tie) & ~inv;
  // start has priority: a result arriving with start is dropped
  assign accept = res_valid & ~start & (state_q == PLAY);
  assign a_nxt  = score_a_q + {3'b000, win_a};
  assign b_nxt  = score_b_q + {3'b000, win_b};
  assign r_nxt  = rounds_q + 4'd1;

`ifdef PPT_INVALID_ABORT_EN
  logic [1:0] inv_cnt_q, inv_cnt_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      score_a_q <= 4'd0;
      score_b_q <= 4'd0;
      rounds_q  <= 4'd0;
      winner_q  <= RES_INV;
`ifdef PPT_INVALID_ABORT_EN
      inv_cnt_q <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      rounds_q  <= rounds_d;
      winner_q  <= winner_d;
`ifdef PPT_INVALID_ABORT_EN
      inv_cnt_q <= inv_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    rounds_d  = rounds_q;
    winner_d  = winner_q;
`ifdef PPT_INVALID_ABORT_EN
    inv_cnt_d = inv_cnt_q;
`endif
    if (start) begin
      state_d   = PLAY;
      score_a_d = 4'd0;
      score_b_d = 4'd0;
      rounds_d  = 4'd0;
      winner_d  = RES_INV;
`ifdef PPT_INVALID_ABORT_EN
      inv_cnt_d = 2'd0;
`endif
    end else if (accept && res_ok) begin
      score_a_d = a_nxt;
      score_b_d = b_nxt;
      rounds_d  = r_nxt;
`ifdef PPT_INVALID_ABORT_EN
      inv_cnt_d = 2'd0;
`endif
      // Decide on the counts including this result so done lands with the same edge
      if (a_nxt == WINS_4) begin
        state_d  = DONE;
        winner_d = RES_A;
      end else if (b_nxt == WINS_4) begin
        state_d  = DONE;
        winner_d = RES_B;
      end else if (r_nxt == MAX_4) begin
        state_d = DONE;
        if (a_nxt > b_nxt) begin
          winner_d = RES_A;
        end else if (b_nxt > a_nxt) begin
          winner_d = RES_B;
        end else begin
          winner_d = RES_TIE;
        end
      end
    end
`ifdef PPT_INVALID_ABORT_EN
    else if (accept && inv) begin
      inv_cnt_d = inv_cnt_q + 2'd1;
      if (inv_cnt_q == 2'd2) begin
        state_d  = DONE;
        winner_d = RES_INV;
      end
    end
`endif
  end

  always_comb begin
    ready   = (state_q == PLAY);
    done    = (state_q == DONE);
    score_a = score_a_q;
    score_b = score_b_q;
    rounds  = rounds_q;
    winner  = winner_q;
  end

endmodule

// File: tb/tb_ppt_placar.sv
// tb/tb_ppt_placar.sv - table, directed and randomized checks of ppt_placar against a match model
module tb_ppt_placar;
  import ppt_pkg::*;

  logic clk = 1'b0;
  logic rst_n, start, res_valid, S1, S2;
  logic       ready0, done0, ready1, done1;
  logic [3:0] sa0, sb0, r0, sa1, sb1, r1;
  logic [1:0] w0, w1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ppt_placar #(.WINS_TO_MATCH(2), .MAX_ROUNDS(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .res_valid(res_valid), .S1(S1), .S2(S2),
    .ready(ready0), .score_a(sa0), .score_b(sb0), .rounds(r0), .done(done0), .winner(w0)
  );

  ppt_placar #(.WINS_TO_MATCH(2), .MAX_ROUNDS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .res_valid(res_valid), .S1(S1), .S2(S2),
    .ready(ready1), .score_a(sa1), .score_b(sb1), .rounds(r1), .done(done1), .winner(w1)
  );

  // Model: match phase (0 idle, 1 play, 2 done) plus plain tallies
  int m0_st, m0_a, m0_b, m0_r, m0_inv;
  int m1_st, m1_a, m1_b, m1_r, m1_inv;
  logic [1:0] m0_w, m1_w;

  function automatic logic [15:0] pack(bit rdy, bit dn, int a, int b, int r, logic [1:0] w);
    return {rdy, dn, 4'(a), 4'(b), 4'(r), w};
  endfunction

  task automatic mstep(input int maxr, input bit s, input bit v, input logic [1:0] c,
                       inout int st, inout int a, inout int b, inout int r, inout int ninv,
                       inout logic [1:0] w);
    if (s) begin
      st = 1; a = 0; b = 0; r = 0; ninv = 0; w = 2'b00;
    end else if (v && st == 1) begin
      if (c == 2'b00) begin
`ifdef PPT_INVALID_ABORT_EN
        ninv = ninv + 1;
        if (ninv == 3) begin
          st = 2; w = 2'b00;
        end
`endif
      end else begin
        ninv = 0;
        r = r + 1;
        if (c == 2'b10) a = a + 1;
        if (c == 2'b01) b = b + 1;
        if (a == 2) begin
          st = 2; w = 2'b10;
        end else if (b == 2) begin
          st = 2; w = 2'b01;
        end else if (r == maxr) begin
          st = 2;
          w = (a > b) ? 2'b10 : (b > a) ? 2'b01 : 2'b11;
        end
      end
    end
  endtask

  task automatic mreset();
    m0_st = 0; m0_a = 0; m0_b = 0; m0_r = 0; m0_inv = 0; m0_w = 2'b00;
    m1_st = 0; m1_a = 0; m1_b = 0; m1_r = 0; m1_inv = 0; m1_w = 2'b00;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got {rdy,done,a,b,r,w}=%h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] got0();
    return {ready0, done0, sa0, sb0, r0, w0};
  endfunction

  function automatic logic [15:0] got1();
    return {ready1, done1, sa1, sb1, r1, w1};
  endfunction

  // Drive inputs just after an edge, sample #1 after the following edge, advance the model
  task automatic tick(input bit s, input bit v, input logic [1:0] c);
    start = s; res_valid = v; {S1, S2} = c;
    @(posedge clk);
    #1;
    mstep(9, s, v, c, m0_st, m0_a, m0_b, m0_r, m0_inv, m0_w);
    mstep(3, s, v, c, m1_st, m1_a, m1_b, m1_r, m1_inv, m1_w);
  endtask

  typedef struct {
    bit         s;
    bit         v;
    logic [1:0] c;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(bit s, bit v, logic [1:0] c, logic [15:0] exp);
    vec_t t;
    t.s = s; t.v = v; t.c = c; t.exp = exp;
    return t;
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; res_valid = 1'b0; S1 = 1'b0; S2 = 1'b0;
    mreset();

    tbl[0]  = mk(0, 1, RES_A,   pack(0, 0, 0, 0, 0, 2'b00));
    tbl[1]  = mk(1, 0, RES_INV, pack(1, 0, 0, 0, 0, 2'b00));
    tbl[2]  = mk(0, 1, RES_A,   pack(1, 0, 1, 0, 1, 2'b00));
    tbl[3]  = mk(0, 1, RES_A,   pack(0, 1, 2, 0, 2, 2'b10));
    tbl[4]  = mk(0, 1, RES_B,   pack(0, 1, 2, 0, 2, 2'b10));
    tbl[5]  = mk(1, 0, RES_INV, pack(1, 0, 0, 0, 0, 2'b00));
    tbl[6]  = mk(0, 1, RES_TIE, pack(1, 0, 0, 0, 1, 2'b00));
    tbl[7]  = mk(0, 1, RES_B,   pack(1, 0, 0, 1, 2, 2'b00));
    tbl[8]  = mk(0, 1, RES_A,   pack(1, 0, 1, 1, 3, 2'b00));
    tbl[9]  = mk(0, 1, RES_B,   pack(0, 1, 1, 2, 4, 2'b01));
    tbl[10] = mk(1, 1, RES_A,   pack(1, 0, 0, 0, 0, 2'b00));
    tbl[11] = mk(0, 1, RES_INV, pack(1, 0, 0, 0, 0, 2'b00));
    tbl[12] = mk(0, 1, RES_INV, pack(1, 0, 0, 0, 0, 2'b00));
    tbl[13] = mk(0, 1, RES_A,   pack(1, 0, 1, 0, 1, 2'b00));
    tbl[14] = mk(0, 1, RES_INV, pack(1, 0, 1, 0, 1, 2'b00));
    tbl[15] = mk(0, 1, RES_INV, pack(1, 0, 1, 0, 1, 2'b00));
`ifdef PPT_INVALID_ABORT_EN
    tbl[16] = mk(0, 1, RES_INV, pack(0, 1, 1, 0, 1, 2'b00));
    tbl[17] = mk(0, 1, RES_A,   pack(0, 1, 1, 0, 1, 2'b00));
`else
    tbl[16] = mk(0, 1, RES_INV, pack(1, 0, 1, 0, 1, 2'b00));
    tbl[17] = mk(0, 1, RES_A,   pack(0, 1, 2, 0, 2, 2'b10));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("reset_main", got0(), pack(0, 0, 0, 0, 0, 2'b00));
    chk("reset_max3", got1(), pack(0, 0, 0, 0, 0, 2'b00));
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].s, tbl[i].v, tbl[i].c);
      chk($sformatf("table_%0d", i), got0(), tbl[i].exp);
    end

    // Round cap with equal scores ends in a draw on the 3-round instance
    tick(1, 0, RES_INV);
    tick(0, 1, RES_A);
    chk("cap_a", got1(), pack(1, 0, 1, 0, 1, 2'b00));
    tick(0, 1, RES_B);
    chk("cap_b", got1(), pack(1, 0, 1, 1, 2, 2'b00));
    tick(0, 1, RES_TIE);
    chk("cap_draw", got1(), pack(0, 1, 1, 1, 3, 2'b11));
    chk("cap_main_live", got0(), pack(1, 0, 1, 1, 3, 2'b00));

    // Asynchronous reset mid-match, observed before the next rising edge
    tick(1, 0, RES_INV);
    tick(0, 1, RES_A);
    chk("pre_reset", got0(), pack(1, 0, 1, 0, 1, 2'b00));
    start = 1'b0; res_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_main", got0(), pack(0, 0, 0, 0, 0, 2'b00));
    chk("async_reset_max3", got1(), pack(0, 0, 0, 0, 0, 2'b00));
    mreset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 400; i++) begin
      bit s, v;
      logic [1:0] c;
      s = ($urandom_range(0, 11) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = 2'($urandom_range(0, 3));
      tick(s, v, c);
      chk($sformatf("rand_main_%0d", i), got0(),
          pack(m0_st == 1, m0_st == 2, m0_a, m0_b, m0_r, m0_w));
      chk($sformatf("rand_max3_%0d", i), got1(),
          pack(m1_st == 1, m1_st == 2, m1_a, m1_b, m1_r, m1_w));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
